pipe_stage_elastic: RTL and testbench

//  Parametrised elastic pipeline register for PC/instruction pairs.

---
 rtl/pipe_stage_elastic.sv | 92 +++++++++
 tb/tb_pipe_stage_elastic.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic PC/instruction pipeline register with a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_* when the main register is empty or draining.
// Backpressure: in_ready is a flop; it falls only after the skid entry fills, so out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   flush                  squash every held entry (same next state as reset)
//   in_valid/in_ready      upstream handshake; in_pc/in_instr are the payload
//   out_valid/out_ready    downstream handshake; out_pc/out_instr show the head entry
//   occ                    number of entries held (0..2)
module pipe_stage_elastic #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occ
);

  // Main register: drives out_* directly.
  logic               m_vld;
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;

  // Skid register: catches the word accepted while M is stalled.
  logic               s_vld;
  logic [PC_W-1:0]    s_pc;
  logic [INSTR_W-1:0] s_instr;

  // Registered copy of ~s_vld so in_ready is a flop output.
  logic               rdy_q;

  logic acc;
  logic dep;

  assign acc = in_valid & rdy_q;
  assign dep = m_vld & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // Flush discards both entries and the word offered this cycle.
      m_vld   <= 1'b0;
      m_pc    <= '0;
      m_instr <= NOP_INSTR;
      s_vld   <= 1'b0;
      rdy_q   <= 1'b1;
    end else if (s_vld) begin
      // Skid full implies M full and in_ready low, so no accept can occur.
      if (dep) begin
        m_pc    <= s_pc;
        m_instr <= s_instr;
        s_vld   <= 1'b0;
        rdy_q   <= 1'b1;
      end
    end else if (!m_vld || dep) begin
      // M empty or draining this cycle: the incoming word goes straight to M.
      if (acc) begin
        m_vld   <= 1'b1;
        m_pc    <= in_pc;
        m_instr <= in_instr;
      end else if (m_vld) begin
        // M empties: reload bubble payload so a stalled empty stage reads as NOP.
        m_vld   <= 1'b0;
        m_pc    <= '0;
        m_instr <= NOP_INSTR;
      end
    end else if (acc) begin
      // M stalled and full: park the word in the skid register.
      s_vld   <= 1'b1;
      s_pc    <= in_pc;
      s_instr <= in_instr;
      rdy_q   <= 1'b0;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = m_vld;
  assign out_pc    = m_pc;
  assign out_instr = m_instr;
  assign occ       = {1'b0, m_vld} + {1'b0, s_vld};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  occ;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected output sequence: {pc, instr} of every accepted, not-yet-consumed word.
  logic [63:0] sb_q[$];

  pipe_stage_elastic #(
    .PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h00000013)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return pc + 32'h00100093;
  endfunction

  // Inputs change only at posedge+1; checks after tick() see the post-edge state.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] pc, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = mk_instr(pc);
    out_ready = ordy;
  endtask

  task automatic chk_empty(input string name);
    chk({name, "_vld"},   {63'd0, out_valid}, 64'd0);
    chk({name, "_instr"}, {32'd0, out_instr}, {32'd0, NOP});
    chk({name, "_pc"},    {32'd0, out_pc},    64'd0);
    chk({name, "_rdy"},   {63'd0, in_ready},  64'd1);
    chk({name, "_occ"},   {62'd0, occ},       64'd0);
  endtask

  // Monitor/scoreboard: runs mid-cycle, compares state and transfers, then
  // updates the expected queue for what the coming edge will commit.
  initial begin
    logic [63:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
      end else begin
        chk("mon_occ",  {62'd0, occ}, 64'(sb_q.size()));
        chk("mon_rdy",  {63'd0, in_ready}, {63'd0, (sb_q.size() < 2) ? 1'b1 : 1'b0});
        chk("mon_vld",  {63'd0, out_valid}, {63'd0, (sb_q.size() > 0) ? 1'b1 : 1'b0});
        if (sb_q.size() == 0)
          chk("mon_bubble", {out_pc, out_instr}, {32'd0, NOP});
        if (flush) begin
          sb_q.delete();
        end else begin
          if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
              chk("mon_spurious", {63'd0, out_valid}, 64'd0);
            end else begin
              exp_w = sb_q.pop_front();
              chk("mon_data", {out_pc, out_instr}, exp_w);
            end
          end
          if (in_valid && in_ready)
            sb_q.push_back({in_pc, in_instr});
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    // Test 1: reset with in_valid high
    drive(1'b1, 1'b0, 1'b1, 32'h000000F0, 1'b1);
    tick();
    tick();
    chk_empty("t1_reset");

    // Test 2: stream 0x0..0xC at full rate
    for (int k = 0; k < 4; k++) begin
      pc = 32'(4 * k);
      drive(1'b0, 1'b0, 1'b1, pc, 1'b1);
      tick();
      chk("t2_pc", {32'd0, out_pc}, {32'd0, pc});
      chk("t2_rdy", {63'd0, in_ready}, 64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("t2_drained", {62'd0, occ}, 64'd0);

    // Test 3: skid fill under stall, then drain in order
    drive(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    tick();
    chk("t3_m", {32'd0, out_pc}, 64'h10);
    drive(1'b0, 1'b0, 1'b1, 32'h14, 1'b0);
    tick();
    chk("t3_occ2", {62'd0, occ}, 64'd2);
    chk("t3_rdy0", {63'd0, in_ready}, 64'd0);
    chk("t3_hold", {32'd0, out_pc}, 64'h10);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("t3_second", {32'd0, out_pc}, 64'h14);
    chk("t3_rdy1", {63'd0, in_ready}, 64'd1);
    tick();
    chk("t3_occ0", {62'd0, occ}, 64'd0);

    // Test 4: flush with both entries held and a word offered
    drive(1'b0, 1'b0, 1'b1, 32'h30, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h34, 1'b0);
    tick();
    chk("t4_occ2", {62'd0, occ}, 64'd2);
    drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
    tick();
    chk("t4_occ0", {62'd0, occ}, 64'd0);
    chk("t4_vld", {63'd0, out_valid}, 64'd0);
    chk("t4_nop", {32'd0, out_instr}, {32'd0, NOP});
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    tick();
    chk("t4_no40", {63'd0, out_valid}, 64'd0);

    // Test 5: reset mid-stream with occ=2, then restart
    drive(1'b0, 1'b0, 1'b1, 32'h50, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h54, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h58, 1'b1);
    tick();
    chk_empty("t5_reset");
    drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    tick();
    chk("t5_first", {out_pc, out_instr}, {32'h100, mk_instr(32'h100)});
    drive(1'b0, 1'b0, 1'b1, 32'h104, 1'b1);
    tick();
    chk("t5_second", {out_pc, out_instr}, {32'h104, mk_instr(32'h104)});
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();

    // Test 6: random traffic checked by the monitor
    for (int k = 0; k < 10000; k++) begin
      rst       = 1'b0;
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      in_instr  = $urandom;
      out_ready = $urandom_range(0, 2) != 0;
      tick();
    end

    // Drain and confirm everything accepted came out.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    tick();
    tick();
    chk("final_occ", {62'd0, occ}, 64'd0);
    @(negedge clk);
    chk("final_sb", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
